// File: rtl/code_lock_pkg.sv
// Shared types and sizing helpers for the code lock validator slice.
package code_lock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    LOCKOUT = 2'd2
  } lock_state_e;

  localparam int ESC_CAP     = 8;
  localparam int ESC_MAX_LVL = $clog2(ESC_CAP);

  function automatic int count_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Timer must hold the longest (fully escalated) lockout.
  function automatic int lockout_w(input int cycles);
    return count_w(cycles * ESC_CAP);
  endfunction

endpackage

// File: rtl/code_lock_validator_lockout_timer.sv
// Loadable lockout down-counter; CODE_LOCK_ESCALATE_EN adds a doubling escalation level.
module lockout_timer
  import code_lock_pkg::*;
#(
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] load_val,
  input  logic             start,
  input  logic             esc_clear,
  output logic             busy,
  output logic             done
);

  localparam int LVL_W = count_w(ESC_MAX_LVL);

  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [CNT_W-1:0] load_s;

`ifdef CODE_LOCK_ESCALATE_EN
  logic [LVL_W-1:0] esc_lvl_r;

  // Escalation level: steps up on each lockout start, capped, cleared by a good code.
  always_ff @(posedge clk) begin
    if (reset) begin
      esc_lvl_r <= {LVL_W{1'b0}};
    end else if (esc_clear) begin
      esc_lvl_r <= {LVL_W{1'b0}};
    end else if (start && (esc_lvl_r != LVL_W'(ESC_MAX_LVL))) begin
      esc_lvl_r <= esc_lvl_r + LVL_W'(1);
    end else begin
      esc_lvl_r <= esc_lvl_r;
    end
  end

  assign load_s = load_val << esc_lvl_r;
`else
  logic unused_esc_s;
  assign unused_esc_s = esc_clear;
  assign load_s       = load_val;
`endif

  // Down-counter; done is raised one cycle early so the consumer's registered
  // response lands exactly load_s cycles after start.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= {CNT_W{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (start) begin
        cnt_r  <= load_s;
        busy_r <= 1'b1;
      end else if (busy_r) begin
        cnt_r <= cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(2)) begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end else begin
          busy_r <= 1'b1;
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: rtl/code_lock_validator.sv
// Multi-digit code validator with failure counting, timed lockout and code reprogramming.
// Optional lockout escalation is enabled by defining CODE_LOCK_ESCALATE_EN.
module code_lock_validator
  import code_lock_pkg::*;
#(
  parameter int DIGIT_W        = 4,
  parameter int CODE_LEN       = 4,
  parameter int MAX_ERRORS     = 3,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DIGIT_W-1:0]                digit_in,
  input  logic                              digit_valid,
  input  logic                              enter,
  input  logic                              clear,
  input  logic                              prog_req,
  input  logic                              lock_open,
  output logic                              code_ok,
  output logic                              code_fail,
  output logic                              prog_done,
  output logic                              locked_out,
  output logic [$clog2(MAX_ERRORS+1)-1:0]   error_count,
  output logic [$clog2(CODE_LEN+1)-1:0]     digit_count
);

  localparam int BUF_W = DIGIT_W * CODE_LEN;
  localparam int EC_W  = $clog2(MAX_ERRORS + 1);
  localparam int DC_W  = $clog2(CODE_LEN + 1);
  localparam int TMR_W = lockout_w(LOCKOUT_CYCLES);

  lock_state_e      state_r;
  logic [BUF_W-1:0] buf_r;
  logic [BUF_W-1:0] stored_r;
  logic [DC_W-1:0]  dcnt_r;
  logic [EC_W-1:0]  ecnt_r;
  logic             code_ok_r;
  logic             code_fail_r;
  logic             prog_done_r;
  logic             locked_out_r;

  logic             full_s;
  logic             match_s;
  logic             prog_mode_s;
  logic             attempt_s;
  logic [EC_W-1:0]  ecnt_inc_s;
  logic             trip_s;
  logic             esc_clear_s;
  logic             tmr_done_s;
  logic             unused_tmr_busy_s;

  // Attempt decode shared by the FSM and the lockout timer.
  always_comb begin
    full_s      = (dcnt_r == DC_W'(CODE_LEN));
    match_s     = full_s && (buf_r == stored_r);
    prog_mode_s = prog_req && lock_open;
    attempt_s   = (state_r != LOCKOUT) && enter && !clear;
    ecnt_inc_s  = ecnt_r + EC_W'(1);
    trip_s      = attempt_s && !prog_mode_s && !match_s && (ecnt_inc_s == EC_W'(MAX_ERRORS));
    esc_clear_s = attempt_s && !prog_mode_s && match_s;
  end

  lockout_timer #(
    .CNT_W (TMR_W)
  ) u_lockout_timer (
    .clk       (clk),
    .reset     (reset),
    .load_val  (TMR_W'(LOCKOUT_CYCLES)),
    .start     (trip_s),
    .esc_clear (esc_clear_s),
    .busy      (unused_tmr_busy_s),
    .done      (tmr_done_s)
  );

  // Main FSM: digit capture, check/program on enter, lockout hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      buf_r        <= {BUF_W{1'b0}};
      stored_r     <= {BUF_W{1'b0}};
      dcnt_r       <= {DC_W{1'b0}};
      ecnt_r       <= {EC_W{1'b0}};
      code_ok_r    <= 1'b0;
      code_fail_r  <= 1'b0;
      prog_done_r  <= 1'b0;
      locked_out_r <= 1'b0;
    end else begin
      code_ok_r   <= 1'b0;
      code_fail_r <= 1'b0;
      prog_done_r <= 1'b0;
      case (state_r)
        IDLE, ENTRY: begin
          if (clear || enter) begin
            buf_r   <= {BUF_W{1'b0}};
            dcnt_r  <= {DC_W{1'b0}};
            state_r <= IDLE;
            if (attempt_s) begin
              if (prog_mode_s) begin
                if (full_s) begin
                  stored_r    <= buf_r;
                  prog_done_r <= 1'b1;
                end else begin
                  stored_r <= stored_r;
                end
              end else if (match_s) begin
                code_ok_r <= 1'b1;
                ecnt_r    <= {EC_W{1'b0}};
              end else begin
                code_fail_r <= 1'b1;
                ecnt_r      <= ecnt_inc_s;
                if (trip_s) begin
                  state_r      <= LOCKOUT;
                  locked_out_r <= 1'b1;
                end else begin
                  locked_out_r <= 1'b0;
                end
              end
            end else begin
              ecnt_r <= ecnt_r;
            end
          end else if (digit_valid) begin
            // Newest digit enters at the bottom; older digits age out of the top.
            buf_r   <= (buf_r << DIGIT_W) | BUF_W'(digit_in);
            state_r <= ENTRY;
            if (!full_s) begin
              dcnt_r <= dcnt_r + DC_W'(1);
            end else begin
              dcnt_r <= dcnt_r;
            end
          end else begin
            state_r <= state_r;
          end
        end
        LOCKOUT: begin
          if (tmr_done_s) begin
            locked_out_r <= 1'b0;
            ecnt_r       <= {EC_W{1'b0}};
            state_r      <= IDLE;
          end else begin
            state_r <= LOCKOUT;
          end
        end
        default: begin
          state_r      <= IDLE;
          buf_r        <= {BUF_W{1'b0}};
          dcnt_r       <= {DC_W{1'b0}};
          locked_out_r <= 1'b0;
        end
      endcase
    end
  end

  assign code_ok     = code_ok_r;
  assign code_fail   = code_fail_r;
  assign prog_done   = prog_done_r;
  assign locked_out  = locked_out_r;
  assign error_count = ecnt_r;
  assign digit_count = dcnt_r;

endmodule

// File: tb/tb_code_lock_validator.sv
// Directed self-checking bench for code_lock_validator with a scoreboard of expected enter responses.
module tb_code_lock_validator;

  localparam int DIGIT_W        = 4;
  localparam int CODE_LEN       = 4;
  localparam int MAX_ERRORS     = 3;
  localparam int LOCKOUT_CYCLES = 10;
  localparam int EC_W           = $clog2(MAX_ERRORS + 1);
  localparam int DC_W           = $clog2(CODE_LEN + 1);
`ifdef CODE_LOCK_ESCALATE_EN
  localparam int SECOND_LEN = 20;
`else
  localparam int SECOND_LEN = 10;
`endif

  // pulse vector order: {code_ok, code_fail, prog_done, locked_out}
  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_OK   = 4'b1000;
  localparam logic [3:0] P_FAIL = 4'b0100;
  localparam logic [3:0] P_PROG = 4'b0010;
  localparam logic [3:0] P_LOCK = 4'b0101;

  typedef struct packed {
    logic [3:0]      pulses;
    logic [EC_W-1:0] err;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic [DIGIT_W-1:0] digit_in;
  logic               digit_valid;
  logic               enter;
  logic               clear;
  logic               prog_req;
  logic               lock_open;
  logic               code_ok;
  logic               code_fail;
  logic               prog_done;
  logic               locked_out;
  logic [EC_W-1:0]    error_count;
  logic [DC_W-1:0]    digit_count;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  code_lock_validator #(
    .DIGIT_W        (DIGIT_W),
    .CODE_LEN       (CODE_LEN),
    .MAX_ERRORS     (MAX_ERRORS),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .enter       (enter),
    .clear       (clear),
    .prog_req    (prog_req),
    .lock_open   (lock_open),
    .code_ok     (code_ok),
    .code_fail   (code_fail),
    .prog_done   (prog_done),
    .locked_out  (locked_out),
    .error_count (error_count),
    .digit_count (digit_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pulses();
    return {code_ok, code_fail, prog_done, locked_out};
  endfunction

  task automatic send_digits(input int n, input logic [19:0] seq);
    for (int i = 0; i < n; i++) begin
      digit_in    = seq[4*(n-1-i) +: 4];
      digit_valid = 1'b1;
      tick();
    end
    digit_valid = 1'b0;
  endtask

  task automatic do_enter(input string tag, input logic [3:0] p, input int err,
                          input bit with_clear, input bit with_digit);
    exp_t e;
    exp_t got;
    e.pulses = p;
    e.err    = err[EC_W-1:0];
    sb.push_back(e);
    enter       = 1'b1;
    clear       = with_clear;
    digit_valid = with_digit;
    digit_in    = 4'd5;
    tick();
    enter       = 1'b0;
    clear       = 1'b0;
    digit_valid = 1'b0;
    got = sb.pop_front();
    check(tag, {28'd0, pulses()}, {28'd0, got.pulses});
    check({tag, "_err"}, {{(32-EC_W){1'b0}}, error_count}, {{(32-EC_W){1'b0}}, got.err});
    check({tag, "_dcnt"}, {{(32-DC_W){1'b0}}, digit_count}, 32'd0);
  endtask

  task automatic trip_lockout();
    send_digits(4, 20'h01235);
    do_enter("wrong1", P_FAIL, 1, 1'b0, 1'b0);
    send_digits(4, 20'h01235);
    do_enter("wrong2", P_FAIL, 2, 1'b0, 1'b0);
    send_digits(4, 20'h01235);
    do_enter("wrong3_lock", P_LOCK, 3, 1'b0, 1'b0);
  endtask

  // locked_out was already seen high in the cycle after the tripping enter.
  task automatic measure_lockout(input int exp_len);
    int len;
    len = 1;
    for (int i = 0; i < 200; i++) begin
      digit_in    = 4'd1;
      digit_valid = (i % 2 == 0);
      enter       = (i % 2 == 1);
      tick();
      check("lock_quiet", {29'd0, code_ok, code_fail, prog_done}, 32'd0);
      if (!locked_out) break;
      len++;
    end
    digit_valid = 1'b0;
    enter       = 1'b0;
    check("lock_len", len, exp_len);
    check("lock_err", {{(32-EC_W){1'b0}}, error_count}, 32'd0);
    check("lock_dcnt", {{(32-DC_W){1'b0}}, digit_count}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; digit_in = 4'd0; digit_valid = 1'b0; enter = 1'b0;
    clear = 1'b0; prog_req = 1'b0; lock_open = 1'b0;
    tick();
    tick();
    check("rst_pulses", {28'd0, pulses()}, 32'd0);
    check("rst_err", {{(32-EC_W){1'b0}}, error_count}, 32'd0);
    check("rst_dcnt", {{(32-DC_W){1'b0}}, digit_count}, 32'd0);
    reset = 1'b0;
    tick();

    // Default stored code is all zeros.
    send_digits(4, 20'h00000);
    check("dcnt_full", {{(32-DC_W){1'b0}}, digit_count}, 32'd4);
    do_enter("zero_ok", P_OK, 0, 1'b0, 1'b0);
    tick();
    check("pulse_one_cycle", {28'd0, pulses()}, 32'd0);

    // Program 1234, then check match and mismatch.
    lock_open = 1'b1; prog_req = 1'b1;
    send_digits(4, 20'h01234);
    do_enter("prog", P_PROG, 0, 1'b0, 1'b0);
    prog_req = 1'b0;
    send_digits(4, 20'h01234);
    do_enter("match", P_OK, 0, 1'b0, 1'b0);
    send_digits(4, 20'h01235);
    do_enter("mismatch", P_FAIL, 1, 1'b0, 1'b0);
    send_digits(4, 20'h01234);
    do_enter("ok_clears_err", P_OK, 0, 1'b0, 1'b0);

    // Consecutive lockouts, then a good code restores the base duration.
    trip_lockout();
    measure_lockout(LOCKOUT_CYCLES);
    trip_lockout();
    measure_lockout(SECOND_LEN);
    send_digits(4, 20'h01234);
    do_enter("ok_after_lock", P_OK, 0, 1'b0, 1'b0);
    trip_lockout();
    measure_lockout(LOCKOUT_CYCLES);

    // Incomplete entry fails; over-long entry keeps the last CODE_LEN digits.
    send_digits(3, 20'h00123);
    do_enter("incomplete", P_FAIL, 1, 1'b0, 1'b0);
    send_digits(5, 20'h91234);
    check("dcnt_sat", {{(32-DC_W){1'b0}}, digit_count}, 32'd4);
    do_enter("long_ok", P_OK, 0, 1'b0, 1'b0);

    // prog_req without lock_open is a plain check; incomplete program stores nothing.
    lock_open = 1'b0; prog_req = 1'b1;
    send_digits(4, 20'h01234);
    do_enter("prog_closed", P_OK, 0, 1'b0, 1'b0);
    lock_open = 1'b1;
    send_digits(2, 20'h00077);
    do_enter("prog_short", P_NONE, 0, 1'b0, 1'b0);
    prog_req = 1'b0;
    send_digits(4, 20'h01234);
    do_enter("prog_short_kept", P_OK, 0, 1'b0, 1'b0);

    // Simultaneous strobes.
    send_digits(2, 20'h00012);
    check("dcnt_two", {{(32-DC_W){1'b0}}, digit_count}, 32'd2);
    do_enter("clear_enter", P_NONE, 0, 1'b1, 1'b0);
    send_digits(4, 20'h01234);
    do_enter("enter_digit", P_OK, 0, 1'b0, 1'b1);
    send_digits(3, 20'h00123);
    clear = 1'b1; digit_valid = 1'b1; digit_in = 4'd4;
    tick();
    clear = 1'b0; digit_valid = 1'b0;
    check("clear_digit", {{(32-DC_W){1'b0}}, digit_count}, 32'd0);
    send_digits(4, 20'h01234);
    do_enter("after_clear", P_OK, 0, 1'b0, 1'b0);

    // Reset during lockout restores everything, including the stored code.
    trip_lockout();
    tick();
    reset = 1'b1;
    tick();
    check("rst_lock", {31'd0, locked_out}, 32'd0);
    check("rst_lock_err", {{(32-EC_W){1'b0}}, error_count}, 32'd0);
    reset = 1'b0;
    send_digits(4, 20'h00000);
    do_enter("rst_code_zero", P_OK, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
